// File: rtl/sseg_pkg.sv
// Shared constants for the multiplexed 7-segment display driver.
// Segment order is {a,b,c,d,e,f,g}, active-low throughout.
package sseg_pkg;

  localparam int MAX_DIGITS = 32;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [MAX_DIGITS-1:0] ANODE_OFF = '1;

  // Indexed by nibble value; entry 15 (F) is listed first.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
    7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
    7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
    7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
  };

  function automatic logic [MAX_DIGITS-1:0] anode_on(
    input int unsigned i
  );
    logic [MAX_DIGITS-1:0] one;
    one = MAX_DIGITS'(1);
    return ANODE_OFF & ~(one << i);
  endfunction

endpackage

// File: rtl/sseg_hex_decoder.sv
// Combinational hex nibble to active-low segment pattern.
// Pure table lookup so the scan path stays one mux deep.
module sseg_hex_decoder
  import sseg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with
// frame-aligned double buffering and leading-zero blanking.
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int N_DIGITS    = 4,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  load,
  input  logic                  blank_lz,
  input  logic                  enable,
  output logic [6:0]            sseg,
  output logic                  dp,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int IW = $clog2(N_DIGITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

  localparam logic [N_DIGITS-1:0] AN_DARK =
    ANODE_OFF[N_DIGITS-1:0];

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;

  logic [N_DIGITS-1:0][3:0] shown_val;
  logic [N_DIGITS-1:0][3:0] pend_val;
  logic [N_DIGITS-1:0]      shown_dp;
  logic [N_DIGITS-1:0]      pend_dp;
  logic                     pend_valid;

  logic                  tick;
  logic                  wrap;
  logic [3:0]            nib;
  logic [6:0]            dec_seg;
  logic [N_DIGITS-1:0]   lz;
  logic                  blank;
  logic [MAX_DIGITS-1:0] an_sel;

  assign tick   = enable && (cnt == CNT_LAST);
  assign wrap   = tick && (idx == IDX_LAST);
  assign nib    = shown_val[idx];
  assign an_sel = anode_on(32'(idx));

  // lz[i]: every shown nibble from the top digit down to i is zero
  always_comb begin
    lz = '0;
    lz[N_DIGITS-1] = (shown_val[N_DIGITS-1] == 4'h0);
    for (int i = N_DIGITS - 2; i >= 0; i--) begin
      lz[i] = lz[i+1] && (shown_val[i] == 4'h0);
    end
  end

  assign blank = blank_lz && (idx != '0) && lz[idx];

  sseg_hex_decoder u_dec (
    .nibble (nib),
    .seg    (dec_seg)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      idx        <= '0;
      shown_val  <= '0;
      pend_val   <= '0;
      shown_dp   <= '0;
      pend_dp    <= '0;
      pend_valid <= 1'b0;
      an         <= AN_DARK;
      sseg       <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if (enable) begin
        cnt <= tick ? '0 : cnt + CW'(1);
        if (tick) begin
          idx <= (idx == IDX_LAST) ? '0 : idx + IW'(1);
        end
      end

      frame_done <= wrap;

      if (wrap && pend_valid) begin
        shown_val  <= pend_val;
        shown_dp   <= pend_dp;
        pend_valid <= 1'b0;
      end

      // A load on the wrap cycle lands after the commit above.
      if (load) begin
        pend_val   <= value;
        pend_dp    <= dp_in;
        pend_valid <= 1'b1;
      end

      if (enable) begin
        an   <= an_sel[N_DIGITS-1:0];
        sseg <= blank ? SEG_BLANK : dec_seg;
        dp   <= ~shown_dp[idx];
      end else begin
        an   <= AN_DARK;
        sseg <= SEG_BLANK;
        dp   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomized self-checking bench for sseg_scan_driver
// against a cycle-level reference model (N=4, DIV=4).
module tb_sseg_scan_driver;

  localparam int ND = 4;
  localparam int RD = 4;

  logic        clk;
  logic        rst;
  logic [15:0] value;
  logic [3:0]  dp_in;
  logic        load;
  logic        blank_lz;
  logic        enable;
  logic [6:0]  sseg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int checks = 0;
  int fails  = 0;

  sseg_scan_driver #(
    .N_DIGITS    (ND),
    .REFRESH_DIV (RD)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .value      (value),
    .dp_in      (dp_in),
    .load       (load),
    .blank_lz   (blank_lz),
    .enable     (enable),
    .sseg       (sseg),
    .dp         (dp),
    .an         (an),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [6:0] segtab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: slot time, digit index and buffers as plain values
  int          m_cnt = 0;
  int          m_idx = 0;
  int          m_dig;
  bit          m_wrap;
  bit          m_pv = 0;
  logic [15:0] m_shown = '0;
  logic [15:0] m_pend = '0;
  logic [3:0]  m_sdp = '0;
  logic [3:0]  m_pdp = '0;
  logic [3:0]  e_an = 4'hF;
  logic [6:0]  e_seg = 7'h7F;
  logic        e_dp = 1'b1;
  logic        e_fd = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_cnt = 0; m_idx = 0; m_pv = 0;
      m_shown = '0; m_pend = '0;
      m_sdp = '0; m_pdp = '0;
      e_an = 4'hF; e_seg = 7'h7F;
      e_dp = 1'b1; e_fd = 1'b0;
    end else begin
      if (enable) begin
        e_an  = ~(4'b0001 << m_idx);
        m_dig = int'((m_shown >> (4 * m_idx)) & 16'hF);
        if (blank_lz && m_idx > 0 &&
            (m_shown >> (4 * m_idx)) == 16'h0)
          e_seg = 7'h7F;
        else
          e_seg = segtab[m_dig];
        e_dp = ~m_sdp[m_idx];
      end else begin
        e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
      end
      m_wrap = enable && m_cnt == RD - 1 && m_idx == ND - 1;
      e_fd = m_wrap;
      if (enable) begin
        if (m_cnt == RD - 1) begin
          m_cnt = 0;
          m_idx = (m_idx + 1) % ND;
        end else begin
          m_cnt++;
        end
      end
      if (m_wrap && m_pv) begin
        m_shown = m_pend; m_sdp = m_pdp; m_pv = 0;
      end
      if (load) begin
        m_pend = value; m_pdp = dp_in; m_pv = 1;
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_wrap();
    int n = 0;
    cycle();
    while (!frame_done && n < 64) begin
      cycle();
      n++;
    end
    checks++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL frame_timeout got fd=%b want 1", frame_done);
    end
  endtask

  task automatic grab_digits(
    output logic [3:0][3:0] ga,
    output logic [3:0][6:0] gs,
    output logic [3:0]      gd
  );
    for (int d = 0; d < ND; d++) begin
      repeat (d == 0 ? 1 : RD) cycle();
      ga[d] = an; gs[d] = sseg; gd[d] = dp;
    end
  endtask

  task automatic capture_frame(
    output logic [3:0][3:0] ga,
    output logic [3:0][6:0] gs,
    output logic [3:0]      gd
  );
    wait_wrap();
    grab_digits(ga, gs, gd);
  endtask

  task automatic load_data(input logic [15:0] v,
                           input logic [3:0] d);
    if (enable && m_cnt == RD - 1 && m_idx == ND - 1)
      cycle();
    value = v; dp_in = d; load = 1'b1;
    cycle();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b1; load = 1'b0;
    blank_lz = 1'b0; value = '0; dp_in = '0;
    repeat (2) cycle();
    checks++;
    if ({an, sseg, dp, frame_done} !==
        {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL reset got an=%b sseg=%b dp=%b fd=%b want 1111 1111111 1 0",
               an, sseg, dp, frame_done);
    end
  endtask

  task automatic test_scan();
    logic [3:0] exp_an;
    logic [3:0] one;
    one = 4'b0001;
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      exp_an = ~(one << (((k - 1) / 4) % 4));
      checks++;
      if (an !== exp_an) begin
        fails++;
        $display("FAIL scan_an k=%0d got %b want %b", k, an, exp_an);
      end
      checks++;
      if (frame_done !== (k == 16)) begin
        fails++;
        $display("FAIL scan_fd k=%0d got %b want %b",
                 k, frame_done, (k == 16));
      end
      checks++;
      if ({an, sseg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        fails++;
        $display("FAIL scan_model got %b %b %b %b want %b %b %b %b",
                 an, sseg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
  endtask

  task automatic test_load_frame();
    logic [3:0][3:0] ga;
    logic [3:0][6:0] gs;
    logic [3:0]      gd;
    load_data(16'h12AF, 4'b0000);
    cycle();
    checks++;
    if (an != 4'hF && sseg !== 7'b0000001) begin
      fails++;
      $display("FAIL early_commit got sseg=%b want 0000001", sseg);
    end
    capture_frame(ga, gs, gd);
    checks++;
    if (gs !== {7'b1001111, 7'b0010010, 7'b0001000, 7'b0111000}) begin
      fails++;
      $display("FAIL frame_12AF got %h want 12AF segs", gs);
    end
    checks++;
    if (ga !== 16'h7BDE) begin
      fails++;
      $display("FAIL frame_an got %h want 7bde", ga);
    end
  endtask

  task automatic test_blank();
    logic [3:0][3:0] ga;
    logic [3:0][6:0] gs;
    logic [3:0]      gd;
    blank_lz = 1'b1;
    load_data(16'h0005, 4'b0000);
    capture_frame(ga, gs, gd);
    checks++;
    if (gs !== {7'h7F, 7'h7F, 7'h7F, 7'b0100100}) begin
      fails++;
      $display("FAIL blank_0005 got %h want blanks+5", gs);
    end
    checks++;
    if (gd !== 4'hF) begin
      fails++;
      $display("FAIL blank_dp got %b want 1111", gd);
    end
    load_data(16'h0000, 4'b0000);
    capture_frame(ga, gs, gd);
    checks++;
    if (gs !== {7'h7F, 7'h7F, 7'h7F, 7'b0000001}) begin
      fails++;
      $display("FAIL blank_0000 got %h want blanks+0", gs);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_dp();
    logic [3:0][3:0] ga;
    logic [3:0][6:0] gs;
    logic [3:0]      gd;
    load_data(16'h8888, 4'b0100);
    capture_frame(ga, gs, gd);
    checks++;
    if (gd !== 4'b1011 || ga !== 16'h7BDE) begin
      fails++;
      $display("FAIL dp_digit2 got dp=%b an=%h want 1011 7bde", gd, ga);
    end
  endtask

  task automatic test_load_on_wrap();
    logic [3:0][3:0] ga;
    logic [3:0][6:0] gs;
    logic [3:0]      gd;
    int n = 0;
    load_data(16'h3333, 4'b0000);
    while (!(m_cnt == RD - 1 && m_idx == ND - 1) && n < 64) begin
      cycle();
      n++;
    end
    value = 16'h4444; load = 1'b1;
    cycle();
    load = 1'b0;
    checks++;
    if (frame_done !== 1'b1) begin
      fails++;
      $display("FAIL wrap_fd got %b want 1", frame_done);
    end
    cycle();
    checks++;
    if (an !== 4'b1110 || sseg !== 7'b0000110) begin
      fails++;
      $display("FAIL wrap_old got an=%b sseg=%b want 1110 0000110",
               an, sseg);
    end
    capture_frame(ga, gs, gd);
    checks++;
    if (gs !== {4{7'b1001100}}) begin
      fails++;
      $display("FAIL wrap_new got %h want 4444 segs", gs);
    end
  endtask

  task automatic test_midreset();
    logic [3:0][3:0] ga;
    logic [3:0][6:0] gs;
    logic [3:0]      gd;
    load_data(16'h9999, 4'b1111);
    cycle();
    rst = 1'b1;
    cycle();
    checks++;
    if ({an, sseg, dp, frame_done} !==
        {4'hF, 7'h7F, 1'b1, 1'b0}) begin
      fails++;
      $display("FAIL midreset got an=%b sseg=%b dp=%b fd=%b want 1111 1111111 1 0",
               an, sseg, dp, frame_done);
    end
    rst = 1'b0;
    cycle();
    checks++;
    if (an !== 4'b1110 || sseg !== 7'b0000001) begin
      fails++;
      $display("FAIL restart got an=%b sseg=%b want 1110 0000001",
               an, sseg);
    end
    capture_frame(ga, gs, gd);
    checks++;
    if (gs !== {4{7'b0000001}} || gd !== 4'hF) begin
      fails++;
      $display("FAIL pend_cleared got %h dp=%b want zeros 1111", gs, gd);
    end
  endtask

  task automatic test_enable();
    logic [3:0] saved;
    int n = 0;
    load_data(16'h5A5A, 4'b0010);
    cycle();
    while (!(m_cnt == 1 && m_idx == 2) && n < 64) begin
      cycle();
      n++;
    end
    saved = an;
    enable = 1'b0;
    cycle();
    checks++;
    if ({an, sseg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
      fails++;
      $display("FAIL dark got an=%b sseg=%b dp=%b want 1111 1111111 1",
               an, sseg, dp);
    end
    for (int k = 0; k < 10; k++) begin
      if (k == 4) load_data(16'hC0DE, 4'b1000);
      else cycle();
      checks++;
      if (an !== 4'hF || frame_done !== 1'b0 ||
          {an, sseg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        fails++;
        $display("FAIL frozen got an=%b fd=%b want 1111 0", an, frame_done);
      end
    end
    enable = 1'b1;
    cycle();
    checks++;
    if (an !== saved || saved !== 4'b1011) begin
      fails++;
      $display("FAIL resume got an=%b want %b (1011)", an, saved);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      rst      = ($urandom % 97) == 0;
      enable   = ($urandom % 8) != 0;
      load     = ($urandom % 6) == 0;
      blank_lz = ($urandom % 3) != 0;
      value    = ($urandom % 2) ? 16'($urandom % 256) : 16'($urandom);
      dp_in    = 4'($urandom);
      cycle();
      checks++;
      if ({an, sseg, dp, frame_done} !== {e_an, e_seg, e_dp, e_fd}) begin
        fails++;
        $display("FAIL rand_model k=%0d got %b %b %b %b want %b %b %b %b",
                 k, an, sseg, dp, frame_done, e_an, e_seg, e_dp, e_fd);
      end
    end
    rst = 1'b0; load = 1'b0; enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1; enable = 1'b1; load = 1'b0;
    blank_lz = 1'b0; value = '0; dp_in = '0;
    @(negedge clk);
    test_reset();
    test_scan();
    test_load_frame();
    test_blank();
    test_dp();
    test_load_on_wrap();
    test_midreset();
    test_enable();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
